// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - Ethernet receive controller: stores one frame into the frame buffer and holds it until the CPU re-arms.
// Optional destination-address filtering is enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_rx_ctrl #(
    parameter int          BUF_AW   = 11,
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              frame_active,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              cr_wr,
    input  logic [7:0]        cr_wdata,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              recv_full,
    output logic [15:0]       recv_len,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int CW = BUF_AW + 1;
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {BUF_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_SKIP,
        S_FULL
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     count, count_n;
    logic              prev_active;
    logic              buf_we_n;
    logic [BUF_AW-1:0] buf_addr_n;
    logic [7:0]        buf_wdata_n;
    logic              recv_full_n;
    logic [15:0]       recv_len_n;
    logic              overflow_n;
    logic [7:0]        drop_cnt_n;

    logic frame_start;
    logic rearm;
    logic unused_cr;

    assign frame_start = frame_active & ~prev_active;
    assign rearm       = cr_wr & ~cr_wdata[0];
    assign unused_cr   = ^cr_wdata[7:1];

`ifdef ETH_RX_MAC_FILTER_EN
    localparam logic [CW-1:0] HDR_LEN = CW'(6);

    // Unicast and broadcast matches are tracked separately; a frame is
    // rejected only once both candidate destinations have been ruled out.
    logic       uni_ok, uni_ok_n;
    logic       bc_ok, bc_ok_n;
    logic [7:0] mac_byte;

    always_comb begin
        case (count[2:0])
            3'd0:    mac_byte = MAC_ADDR[47:40];
            3'd1:    mac_byte = MAC_ADDR[39:32];
            3'd2:    mac_byte = MAC_ADDR[31:24];
            3'd3:    mac_byte = MAC_ADDR[23:16];
            3'd4:    mac_byte = MAC_ADDR[15:8];
            3'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'hFF;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            count       <= '0;
            prev_active <= 1'b1;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            recv_full   <= 1'b0;
            recv_len    <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
            uni_ok      <= 1'b1;
            bc_ok       <= 1'b1;
`endif
        end else begin
            state       <= state_n;
            count       <= count_n;
            prev_active <= frame_active;
            buf_we      <= buf_we_n;
            buf_addr    <= buf_addr_n;
            buf_wdata   <= buf_wdata_n;
            recv_full   <= recv_full_n;
            recv_len    <= recv_len_n;
            overflow    <= overflow_n;
            drop_cnt    <= drop_cnt_n;
`ifdef ETH_RX_MAC_FILTER_EN
            uni_ok      <= uni_ok_n;
            bc_ok       <= bc_ok_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        buf_we_n    = 1'b0;
        buf_addr_n  = buf_addr;
        buf_wdata_n = buf_wdata;
        recv_full_n = recv_full;
        recv_len_n  = recv_len;
        overflow_n  = overflow;
        drop_cnt_n  = drop_cnt;
`ifdef ETH_RX_MAC_FILTER_EN
        uni_ok_n    = uni_ok;
        bc_ok_n     = bc_ok;
`endif

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_n    = S_RECV;
                    count_n    = '0;
                    overflow_n = 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
                    uni_ok_n   = 1'b1;
                    bc_ok_n    = 1'b1;
`endif
                end
            end

            S_RECV: begin
                if (byte_valid) begin
                    if (count < MAX_LEN) begin
                        buf_we_n    = 1'b1;
                        buf_addr_n  = count[BUF_AW-1:0];
                        buf_wdata_n = byte_data;
                        count_n     = count + CW'(1);
                    end else begin
                        overflow_n  = 1'b1;
                    end
`ifdef ETH_RX_MAC_FILTER_EN
                    if (count < HDR_LEN) begin
                        uni_ok_n = uni_ok && (byte_data == mac_byte);
                        bc_ok_n  = bc_ok && (byte_data == 8'hFF);
                    end
`endif
                end
                // A byte arriving with the falling edge of frame_active is
                // already folded into count_n, so the length includes it.
`ifdef ETH_RX_MAC_FILTER_EN
                if (!uni_ok_n && !bc_ok_n) begin
                    state_n = frame_active ? S_SKIP : S_IDLE;
                end else if (!frame_active) begin
                    if (count_n >= HDR_LEN) begin
                        state_n     = S_FULL;
                        recv_full_n = 1'b1;
                        recv_len_n  = 16'(count_n);
                    end else begin
                        state_n     = S_IDLE;
                    end
                end
`else
                if (!frame_active) begin
                    if (count_n != '0) begin
                        state_n     = S_FULL;
                        recv_full_n = 1'b1;
                        recv_len_n  = 16'(count_n);
                    end else begin
                        state_n     = S_IDLE;
                    end
                end
`endif
            end

            S_SKIP: begin
                if (!frame_active) begin
                    state_n = S_IDLE;
                end
            end

            S_FULL: begin
                if (frame_start && (drop_cnt != 8'hFF)) begin
                    drop_cnt_n = drop_cnt + 8'd1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Re-arm overrides whatever the state logic decided this cycle.
        if (rearm) begin
            state_n     = frame_active ? S_SKIP : S_IDLE;
            recv_full_n = 1'b0;
            recv_len_n  = '0;
            overflow_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - Randomized self-checking bench for eth_rx_ctrl against a frame-level reference model.
module tb_eth_rx_ctrl;

    localparam int          BUF_AW  = 11;
    localparam int          MAX_LEN = 1 << BUF_AW;
    localparam logic [47:0] MAC     = 48'h02_00_00_00_00_01;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              frame_active = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              cr_wr = 1'b0;
    logic [7:0]        cr_wdata = 8'h00;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              recv_full;
    logic [15:0]       recv_len;
    logic              overflow;
    logic [7:0]        drop_cnt;

    eth_rx_ctrl #(.BUF_AW(BUF_AW), .MAC_ADDR(MAC)) dut (
        .clk(clk), .n_rst(n_rst), .frame_active(frame_active),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .cr_wr(cr_wr), .cr_wdata(cr_wdata),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .recv_full(recv_full), .recv_len(recv_len),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the controller should report at frame level.
    bit  m_full;
    int  m_len;
    bit  m_ovf;
    int  m_drop;
    bq_t exp_q;
    bit  exp_wr_valid;

    bq_t wr_data_q;
    int  wr_addr_q[$];

    always @(negedge clk) begin
        if (n_rst && buf_we) begin
            wr_addr_q.push_back(int'(buf_addr));
            wr_data_q.push_back(buf_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // kind 0: station address, 1: broadcast, 2: station address with last byte 02
    function automatic bq_t make_frame(input int n, input int kind);
        bq_t  q;
        logic [47:0] mac = MAC;
        for (int i = 0; i < n; i++) begin
            if (i < 6 && kind == 1)               q.push_back(8'hFF);
            else if (i == 5 && kind == 2)         q.push_back(8'h02);
            else if (i < 6 && (kind == 0 || kind == 2)) q.push_back(mac[47-8*i -: 8]);
            else                                  q.push_back(8'($urandom));
        end
        return q;
    endfunction

    function automatic bit frame_ok(input bq_t f);
`ifdef ETH_RX_MAC_FILTER_EN
        bit uni = 1'b1;
        bit bc  = 1'b1;
        logic [47:0] mac = MAC;
        if (f.size() < 6) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            uni = uni && (f[i] == mac[47-8*i -: 8]);
            bc  = bc && (f[i] == 8'hFF);
        end
        return uni || bc;
`else
        return f.size() >= 1;
`endif
    endfunction

    // Returns -1 when the observed writes equal the expected list.
    function automatic int first_write_err();
        int n = (wr_data_q.size() < exp_q.size()) ? wr_data_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== exp_q[i]) return i;
        if (wr_data_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_len = 0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic do_cr(input logic [7:0] val);
        cr_wr = 1'b1; cr_wdata = val;
        @(negedge clk);
        cr_wr = 1'b0;
        @(negedge clk);
        if (!val[0]) begin m_full = 0; m_len = 0; m_ovf = 0; end
    endtask

    task automatic run_frame(input bq_t fr, input int gap_max, input bit fall_last,
                             input int rearm_at, input bit rearm_end);
        int n      = fr.size();
        bit armed  = !m_full;
        bit mid    = (rearm_at >= 0) && (rearm_at < n);
        bit cut    = mid || rearm_end;
        int lim    = mid ? rearm_at : n;
        bit ok     = frame_ok(fr);
        exp_q = {};
        if (armed) for (int i = 0; i < lim && i < MAX_LEN; i++) exp_q.push_back(fr[i]);
`ifdef ETH_RX_MAC_FILTER_EN
        exp_wr_valid = !(armed && !ok);
`else
        exp_wr_valid = 1'b1;
`endif
        wr_data_q.delete(); wr_addr_q.delete();

        frame_active = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == rearm_at) begin
                cr_wr = 1'b1; cr_wdata = 8'hFE;
                @(negedge clk);
                cr_wr = 1'b0;
            end
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            byte_valid = 1'b1; byte_data = fr[i];
            if (fall_last && i == n - 1) begin
                frame_active = 1'b0;
                if (rearm_end) begin cr_wr = 1'b1; cr_wdata = 8'h00; end
            end
            @(negedge clk);
            byte_valid = 1'b0; cr_wr = 1'b0;
        end
        if (!(fall_last && n > 0)) begin
            frame_active = 1'b0;
            if (rearm_end) begin cr_wr = 1'b1; cr_wdata = 8'h00; end
            @(negedge clk);
            cr_wr = 1'b0;
        end
        repeat (2) @(negedge clk);

        if (!armed) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        if (cut) begin
            m_full = 0; m_len = 0; m_ovf = 0;
        end else if (armed) begin
            m_ovf = ok && (n > MAX_LEN);
            if (ok) begin m_full = 1; m_len = (n < MAX_LEN) ? n : MAX_LEN; end
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({buf_we, buf_addr, buf_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_buf: we/addr/data=%b/%0h/%0h required 0/0/0", buf_we, buf_addr, buf_wdata);
        end
        n_checks++;
        if ({recv_full, recv_len, overflow} !== '0) begin
            n_fail++; $display("FAIL reset_status: full=%b len=%0d ovf=%b required 0/0/0", recv_full, recv_len, overflow);
        end
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_drop: drop_cnt=%0d required 0", drop_cnt);
        end
        n_rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bq_t fr = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'hAA, 8'h55, 8'h73, 8'h87};
        int  e;
        run_frame(fr, 2, 1'b0, -1, 1'b0);
        e = first_write_err();
        n_checks++;
        if (exp_wr_valid && e >= 0) begin
            n_fail++; $display("FAIL basic_writes: %0d writes seen, %0d required, first bad index %0d", wr_data_q.size(), exp_q.size(), e);
        end
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len)) begin
            n_fail++; $display("FAIL basic_status: full=%b len=%0d required %b/%0d", recv_full, recv_len, m_full, m_len);
        end
    endtask

    task automatic test_drop_when_full();
        int e;
        if (!m_full) run_frame(make_frame(10, 0), 1, 1'b0, -1, 1'b0);
        run_frame(make_frame(14, 0), 1, 1'b0, -1, 1'b0);
        e = first_write_err();
        n_checks++;
        if (e >= 0) begin
            n_fail++; $display("FAIL full_no_write: %0d writes seen, %0d required", wr_data_q.size(), exp_q.size());
        end
        n_checks++;
        if (drop_cnt !== 8'(m_drop) || recv_len !== 16'(m_len) || recv_full !== m_full) begin
            n_fail++; $display("FAIL full_drop: drop=%0d len=%0d full=%b required %0d/%0d/%b", drop_cnt, recv_len, recv_full, m_drop, m_len, m_full);
        end
    endtask

    task automatic test_rearm_mid_frame();
        int e;
        run_frame(make_frame(14, 0), 1, 1'b0, 10, 1'b0);
        e = first_write_err();
        n_checks++;
        if (e >= 0 || recv_full !== m_full) begin
            n_fail++; $display("FAIL rearm_skip: writes=%0d full=%b required %0d/%b", wr_data_q.size(), recv_full, exp_q.size(), m_full);
        end
        run_frame(make_frame(13, 0), 2, 1'b0, -1, 1'b0);
        e = first_write_err();
        n_checks++;
        if (e >= 0) begin
            n_fail++; $display("FAIL rearm_next_writes: %0d writes seen, %0d required, first bad index %0d", wr_data_q.size(), exp_q.size(), e);
        end
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len)) begin
            n_fail++; $display("FAIL rearm_next_status: full=%b len=%0d required %b/%0d", recv_full, recv_len, m_full, m_len);
        end
    endtask

    task automatic test_cr_write();
        do_cr(8'h01);
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len)) begin
            n_fail++; $display("FAIL cr_noop: full=%b len=%0d required %b/%0d", recv_full, recv_len, m_full, m_len);
        end
        do_cr(8'hFE);
        n_checks++;
        if (recv_full !== 1'b0 || recv_len !== 16'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL cr_rearm: full=%b len=%0d ovf=%b required 0/0/0", recv_full, recv_len, overflow);
        end
    endtask

    task automatic test_end_cases();
        int e;
        run_frame(make_frame(7, 0), 1, 1'b1, -1, 1'b0);
        e = first_write_err();
        n_checks++;
        if (e >= 0 || recv_len !== 16'(m_len) || recv_full !== m_full) begin
            n_fail++; $display("FAIL fall_with_byte: writes=%0d len=%0d full=%b required %0d/%0d/%b", wr_data_q.size(), recv_len, recv_full, exp_q.size(), m_len, m_full);
        end
        do_cr(8'h00);
        run_frame(make_frame(0, 0), 0, 1'b0, -1, 1'b0);
        n_checks++;
        if (recv_full !== 1'b0 || wr_data_q.size() != 0) begin
            n_fail++; $display("FAIL empty_frame: full=%b writes=%0d required 0/0", recv_full, wr_data_q.size());
        end
        run_frame(make_frame(8, 0), 1, 1'($urandom_range(1, 0)), -1, 1'b1);
        n_checks++;
        if (recv_full !== 1'b0 || recv_len !== 16'd0) begin
            n_fail++; $display("FAIL rearm_at_end: full=%b len=%0d required 0/0", recv_full, recv_len);
        end
        run_frame(make_frame(9, 0), 1, 1'b0, -1, 1'b0);
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len)) begin
            n_fail++; $display("FAIL after_end_rearm: full=%b len=%0d required %b/%0d", recv_full, recv_len, m_full, m_len);
        end
    endtask

    task automatic test_overflow();
        int e;
        if (m_full) do_cr(8'h00);
        run_frame(make_frame(MAX_LEN + 3, 0), 0, 1'b0, -1, 1'b0);
        e = first_write_err();
        n_checks++;
        if (e >= 0) begin
            n_fail++; $display("FAIL ovf_writes: %0d writes seen, %0d required, first bad index %0d", wr_data_q.size(), exp_q.size(), e);
        end
        n_checks++;
        if (overflow !== m_ovf || recv_len !== 16'(m_len) || recv_full !== m_full) begin
            n_fail++; $display("FAIL ovf_status: ovf=%b len=%0d full=%b required %b/%0d/%b", overflow, recv_len, recv_full, m_ovf, m_len, m_full);
        end
        do_cr(8'h00);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_filter();
        if (m_full) do_cr(8'h00);
        run_frame(make_frame(12, 2), 1, 1'b0, -1, 1'b0);
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len)) begin
            n_fail++; $display("FAIL filter_miss: full=%b len=%0d required %b/%0d", recv_full, recv_len, m_full, m_len);
        end
        if (m_full) do_cr(8'h00);
        run_frame(make_frame(12, 1), 1, 1'b0, -1, 1'b0);
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len) || first_write_err() >= 0) begin
            n_fail++; $display("FAIL filter_bcast: full=%b len=%0d writes=%0d required %b/%0d/%0d", recv_full, recv_len, wr_data_q.size(), m_full, m_len, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int n    = ($urandom_range(9, 0) == 0) ? int'($urandom_range(5, 0)) : int'($urandom_range(40, 6));
            int rat  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
            bit rend = ($urandom_range(7, 0) == 0);
            int e;
            if (m_full && $urandom_range(1, 0) == 1) do_cr(8'($urandom_range(127, 0)) << 1);
            run_frame(make_frame(n, int'($urandom_range(2, 0))), 3, 1'($urandom_range(1, 0)), rat, rend);
            e = first_write_err();
            n_checks++;
            if (exp_wr_valid && e >= 0) begin
                n_fail++; $display("FAIL rand%0d_writes: %0d writes seen, %0d required, first bad index %0d", it, wr_data_q.size(), exp_q.size(), e);
            end
            n_checks++;
            if (recv_full !== m_full || recv_len !== 16'(m_len) || overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL rand%0d_status: full=%b len=%0d ovf=%b drop=%0d required %b/%0d/%b/%0d", it, recv_full, recv_len, overflow, drop_cnt, m_full, m_len, m_ovf, m_drop);
            end
        end
    endtask

    task automatic test_drop_saturation();
        if (!m_full) run_frame(make_frame(10, 0), 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 260; i++) begin
            run_frame(make_frame(0, 0), 0, 1'b0, -1, 1'b0);
            n_checks++;
            if (drop_cnt !== 8'(m_drop)) begin
                n_fail++; $display("FAIL drop_sat%0d: drop=%0d required %0d", i, drop_cnt, m_drop);
                break;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_active = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        model_reset();
        wr_data_q.delete(); wr_addr_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) n_rst = 1'b1;
            byte_valid = 1'b1; byte_data = 8'($urandom);
            @(negedge clk);
            byte_valid = 1'b0;
            @(negedge clk);
        end
        frame_active = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (recv_full !== 1'b0 || wr_data_q.size() != 0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid_frame: full=%b writes=%0d drop=%0d required 0/0/0", recv_full, wr_data_q.size(), drop_cnt);
        end
        run_frame(make_frame(11, 0), 1, 1'b0, -1, 1'b0);
        n_checks++;
        if (recv_full !== m_full || recv_len !== 16'(m_len) || first_write_err() >= 0) begin
            n_fail++; $display("FAIL reset_next_frame: full=%b len=%0d writes=%0d required %b/%0d/%0d", recv_full, recv_len, wr_data_q.size(), m_full, m_len, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_when_full();
        test_rearm_mid_frame();
        test_cr_write();
        test_end_cases();
        test_overflow();
        test_filter();
        test_random();
        test_drop_saturation();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_rx_ctrl.md
ETH_RX_CTRL -- requirements
Module: eth_rx_ctrl

Interface
REQ-001 Parameter BUF_AW, default 11, frame-buffer address width; capacity MAX_LEN = 2**BUF_AW bytes.
REQ-002 Parameter MAC_ADDR, default 48'h02_00_00_00_00_01, station address; byte 0 of a frame compares to [47:40].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 frame_active  input  1  synchronized inverse of n_recv_ss; high while a frame is on the wire.
REQ-006 byte_valid  input  1  one-cycle strobe: deserializer has a complete byte.
REQ-007 byte_data  input  8  received byte, valid with byte_valid.
REQ-008 cr_wr  input  1  one-cycle strobe: CPU write to control register (FB00).
REQ-009 cr_wdata  input  8  CPU write data, valid with cr_wr.
REQ-010 buf_we  output  1  one-cycle frame-buffer write strobe.
REQ-011 buf_addr  output  BUF_AW  frame-buffer write address.
REQ-012 buf_wdata  output  8  frame-buffer write data.
REQ-013 recv_full  output  1  frame ready; CR bit 0.
REQ-014 recv_len  output  16  stored frame length in bytes (FB02/FB03).
REQ-015 overflow  output  1  last stored frame exceeded MAX_LEN; CR bit 1.
REQ-016 drop_cnt  output  8  saturating count of frames dropped while full.

Function
REQ-017 States: IDLE (armed), RECV, SKIP (discard remainder of frame), FULL.
REQ-018 Frame start = frame_active rising edge, detected against a registered previous value.
REQ-019 IDLE, frame start -> RECV; byte counter cleared to 0; overflow cleared.
REQ-020 RECV, byte_valid, count < MAX_LEN -> next cycle buf_we=1, buf_addr=count[BUF_AW-1:0], buf_wdata=byte_data; count increments.
REQ-021 RECV, byte_valid, count = MAX_LEN -> no write; overflow set; count holds.
REQ-022 RECV, frame_active low, count > 0 -> FULL; next cycle recv_full=1, recv_len=count zero-extended.
REQ-023 RECV, frame_active low, count = 0 -> IDLE; recv_full stays 0.
REQ-024 byte_valid in the same cycle as frame_active falling is stored and counted.
REQ-025 FULL: buf_we held 0; each frame start increments drop_cnt, saturating at 255.
REQ-026 cr_wr with cr_wdata[0]=0 in any state = re-arm: recv_full=0, recv_len=0, overflow=0; next state SKIP if frame_active high, else IDLE.
REQ-027 Re-arm in RECV discards the partial frame; that frame never sets recv_full.
REQ-028 Re-arm in the same cycle as frame end discards the frame and enters IDLE.
REQ-029 cr_wr with cr_wdata[0]=1: no effect.
REQ-030 SKIP: no buffer writes; frame_active low -> IDLE.

Reset
REQ-031 n_rst low: state IDLE, count 0, buf_we 0, buf_addr 0, buf_wdata 0, recv_full 0, recv_len 0, overflow 0, drop_cnt 0.
REQ-032 Previous-frame_active register resets to 1, so a frame already in progress at reset release is ignored.

Configuration
REQ-033 Macro ETH_RX_MAC_FILTER_EN defined: in RECV, bytes 0-5 are compared to MAC_ADDR or to all-FF (broadcast).
REQ-034 With the filter, any byte mismatch -> SKIP without recv_full; bytes already written stay in the buffer and recv_len is unchanged.
REQ-035 With the filter, a frame ending with count < 6 -> IDLE, discarded.
REQ-036 Macro ETH_RX_MAC_FILTER_EN undefined: no comparison; every frame of 1 or more bytes is accepted.

Verification
REQ-037 Armed, 10-byte frame FE FA F6 F2 EE EA AA 55 73 87 -> 10 buf_we pulses at addr 0-9 with the same data; recv_full=1; recv_len=10.
REQ-038 Full, second 14-byte frame -> no buf_we; drop_cnt=1; recv_len stays 10.
REQ-039 Re-arm write 0xFE after byte 10 of a 14-byte frame -> recv_full=0, state SKIP, no writes for the remainder; next 13-byte frame -> recv_len=13, addr 0-12 written.
REQ-040 Frame of MAX_LEN+3 bytes -> MAX_LEN writes, overflow=1, recv_len=MAX_LEN.
REQ-041 Filter on, destination 02 00 00 00 00 02 -> SKIP, recv_full=0; destination FF FF FF FF FF FF -> accepted.
REQ-042 n_rst released mid-frame -> frame ignored, recv_full=0; next frame is accepted.
